// File: rtl/bin_frac_mult_arbiter_if.sv
// Bundles both requester ports, the shared response bus and the sequential
// multiplier handshake of bin_frac_mult_arbiter.
interface bin_frac_mult_arbiter_if #(
    parameter int W = 7
);
    logic             req0;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic             ack0;
    logic             req1;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic             ack1;
    logic             rsp_valid;
    logic             rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic [W-1:0]     rsp_round;
    logic             rsp_err;
    logic             busy;
    logic             mult_start;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic             mult_done;
    logic [2*W-1:0]   mult_product;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, mult_done, mult_product,
        output ack0, ack1, rsp_valid, rsp_id, rsp_product, rsp_round, rsp_err,
               busy, mult_start, mult_a, mult_b
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, mult_done, mult_product,
        input  ack0, ack1, rsp_valid, rsp_id, rsp_product, rsp_round, rsp_err,
               busy, mult_start, mult_a, mult_b
    );
endinterface

// File: rtl/bin_frac_mult_arbiter.sv
// Round-robin sharing of one sequential Q0.W fractional multiplier between two
// requesters, with a post-start guard cycle against stale done and a timeout.
module bin_frac_mult_arbiter #(
    parameter int W       = 7,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    bin_frac_mult_arbiter_if.slave       bus
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_1  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_timeout_hit;

    logic              r_last_grant;
    logic [TW-1:0]     r_timer;
    logic [W-1:0]      r_mult_a;
    logic [W-1:0]      r_mult_b;
    logic              r_mult_start;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_rsp_id;
    logic [2*W-1:0]    r_rsp_product;
    logic [W-1:0]      r_rsp_round;
    logic              r_rsp_err;

    // Round half-up of the upper fraction; saturates instead of wrapping.
    function automatic logic [W-1:0] round_frac(input logic [2*W-1:0] p);
        logic [W:0] s;
        s = {1'b0, p[2*W-1:W]} + {{W{1'b0}}, p[W-1]};
        if (s[W]) begin
            round_frac = {W{1'b1}};
        end else begin
            round_frac = s[W-1:0];
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and round-robin grant selection.
    always_comb begin
        w_next        = r_state;
        w_grant_vld   = bus.req0 | bus.req1;
        w_timeout_hit = (r_timer == TMAX);
        if (bus.req0 && bus.req1) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = bus.req1;
        end
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: w_next = S_GUARD;
            S_GUARD: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.mult_done || w_timeout_hit) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, timer, result capture and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant  <= 1'b1;
            r_timer       <= {TW{1'b0}};
            r_mult_a      <= {W{1'b0}};
            r_mult_b      <= {W{1'b0}};
            r_mult_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_product <= {(2*W){1'b0}};
            r_rsp_round   <= {W{1'b0}};
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_mult_a     <= w_grant_id ? bus.a1 : bus.a0;
                        r_mult_b     <= w_grant_id ? bus.b1 : bus.b0;
                        r_rsp_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                S_START: r_timer <= {TW{1'b0}};
                S_WAIT: begin
                    if (bus.mult_done) begin
                        r_rsp_product <= bus.mult_product;
                        r_rsp_round   <= round_frac(bus.mult_product);
                        r_rsp_err     <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_rsp_product <= {(2*W){1'b0}};
                        r_rsp_round   <= {W{1'b0}};
                        r_rsp_err     <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TIMER_1;
                    end
                end
                default: ;
            endcase
            // Outputs are registered from the next state so they align with it.
            r_mult_start <= (w_next == S_START);
            r_busy       <= (w_next != S_IDLE);
            r_rsp_valid  <= (w_next == S_RESP);
            r_ack0       <= (w_next == S_RESP) && !r_rsp_id;
            r_ack1       <= (w_next == S_RESP) &&  r_rsp_id;
        end
    end

    assign bus.mult_start  = r_mult_start;
    assign bus.mult_a      = r_mult_a;
    assign bus.mult_b      = r_mult_b;
    assign bus.busy        = r_busy;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_product = r_rsp_product;
    assign bus.rsp_round   = r_rsp_round;
    assign bus.rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_bin_frac_mult_arbiter.sv
// Scoreboard bench for bin_frac_mult_arbiter with a behavioural sequential
// multiplier whose done delay, stale-done hold and product can be steered.
module tb_bin_frac_mult_arbiter;

    localparam int W = 7;

    typedef struct {
        logic         id;
        logic [6:0]   a;
        logic [6:0]   b;
        logic [13:0]  p;
        logic [6:0]   r;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin_frac_mult_arbiter_if #(.W(W)) bus ();

    bin_frac_mult_arbiter #(.W(W), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Multiplier model controls
    int           m_delay     = 8;
    logic         m_never     = 1'b0;
    logic         m_stale     = 1'b0;
    logic         m_force_en  = 1'b0;
    logic [13:0]  m_force_val = 14'h0000;
    logic         m_done      = 1'b0;
    logic         m_drop      = 1'b0;
    logic [13:0]  m_prod      = 14'h0000;
    logic [13:0]  m_pend      = 14'h0000;
    int           m_cnt       = -1;

    assign bus.mult_done    = m_done;
    assign bus.mult_product = m_prod;

    // Done is a level: it stays up until the next start (or one cycle longer in stale mode).
    always @(posedge clk) begin
        if (bus.mult_start) begin
            m_pend <= m_force_en ? m_force_val : (14'(bus.mult_a) * 14'(bus.mult_b));
            m_cnt  <= m_never ? -1 : m_delay;
            if (m_stale) m_drop <= 1'b1;
            else         m_done <= 1'b0;
        end else begin
            if (m_drop) begin
                m_done <= 1'b0;
                m_drop <= 1'b0;
            end
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_prod <= m_pend;
                m_cnt  <= -1;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: start-pulse width, ack protocol and scoreboard compare.
    initial begin
        int   cyc;
        int   t_start;
        int   st_w;
        exp_t e;
        cyc = 0; t_start = 0; st_w = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.mult_start) begin
                if (st_w == 0) t_start = cyc;
                st_w++;
            end else if (st_w != 0) begin
                chk("start_width", st_w, 1);
                st_w = 0;
            end
            if (bus.ack0 || bus.ack1 || bus.rsp_valid) begin
                if (!bus.rsp_valid || (bus.ack0 && bus.ack1)) begin
                    n_tests++; n_fail++;
                    $display("FAIL ack_proto: valid=%0b ack0=%0b ack1=%0b required one ack with valid",
                             bus.rsp_valid, bus.ack0, bus.ack1);
                end else if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: id=%0d with empty scoreboard", bus.rsp_id);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",      bus.rsp_id, e.id);
                    chk("ack_line",    {bus.ack1, bus.ack0}, e.id ? 2'b10 : 2'b01);
                    chk("rsp_product", bus.rsp_product, e.p);
                    chk("rsp_round",   bus.rsp_round, e.r);
                    chk("rsp_err",     bus.rsp_err, e.err);
                    chk("mult_a_hold", bus.mult_a, e.a);
                    chk("mult_b_hold", bus.mult_b, e.b);
                    chk("busy_resp",   bus.busy, 1'b1);
                    chk("latency",     cyc - t_start, e.lat);
                end
            end
        end
    end

    task automatic push_exp(input logic id, input logic [6:0] a, input logic [6:0] b,
                            input logic [13:0] p, input logic [6:0] r, input logic err, input int lat);
        exp_t e;
        e.id = id; e.a = a; e.b = b; e.p = p; e.r = r; e.err = err; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run_req(input logic id, input logic [6:0] a, input logic [6:0] b,
                           input logic [13:0] p, input logic [6:0] r, input logic err,
                           input int lat, input logic early);
        logic got;
        push_exp(id, a, b, p, r, err, lat);
        if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
        else    begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (early && bus.mult_start) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            if (id ? bus.ack1 : bus.ack0) got = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL ack_wait: id=%0d no ack within 200 cycles", id);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    bus.busy, 1'b0);
        chk({tag, "_acks"},    {bus.ack1, bus.ack0, bus.rsp_valid}, 3'b000);
        chk({tag, "_start"},   bus.mult_start, 1'b0);
        chk({tag, "_product"}, bus.rsp_product, 14'h0000);
        chk({tag, "_round"},   bus.rsp_round, 7'h00);
        chk({tag, "_err_id"},  {bus.rsp_err, bus.rsp_id}, 2'b00);
        chk({tag, "_ops"},     {bus.mult_a, bus.mult_b}, 14'h0000);
    endtask

    initial begin
        int acks;
        bus.req0 = 1'b0; bus.a0 = 7'h00; bus.b0 = 7'h00;
        bus.req1 = 1'b0; bus.a1 = 7'h00; bus.b1 = 7'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Basic transaction
        run_req(1'b0, 7'h40, 7'h40, 14'h1000, 7'h20, 1'b0, 10, 1'b0);

        // Both requesters held: grants alternate 0,1,0,1 from reset
        do_reset();
        push_exp(1'b0, 7'h40, 7'h40, 14'h1000, 7'h20, 1'b0, 10);
        push_exp(1'b1, 7'h7F, 7'h7F, 14'h3F01, 7'h7E, 1'b0, 10);
        push_exp(1'b0, 7'h40, 7'h40, 14'h1000, 7'h20, 1'b0, 10);
        push_exp(1'b1, 7'h7F, 7'h7F, 14'h3F01, 7'h7E, 1'b0, 10);
        bus.a0 = 7'h40; bus.b0 = 7'h40; bus.a1 = 7'h7F; bus.b1 = 7'h7F;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        acks = 0;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) acks++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr_ack_count", acks, 4);

        // Rounding up and down
        run_req(1'b0, 7'h60, 7'h05, 14'h01E0, 7'h04, 1'b0, 10, 1'b0);
        run_req(1'b0, 7'h60, 7'h03, 14'h0120, 7'h02, 1'b0, 10, 1'b0);

        // Stale done held through START and GUARD
        m_stale = 1'b1; m_delay = 5;
        run_req(1'b0, 7'h21, 7'h11, 14'h0231, 7'h04, 1'b0, 7, 1'b0);
        m_stale = 1'b0; m_delay = 8;

        // Timeout, then a normal completion
        m_never = 1'b1;
        run_req(1'b1, 7'h55, 7'h2A, 14'h0000, 7'h00, 1'b1, 34, 1'b0);
        m_never = 1'b0;
        run_req(1'b0, 7'h7F, 7'h01, 14'h007F, 7'h01, 1'b0, 10, 1'b0);

        // Rounding saturation; req dropped right after grant still completes
        m_force_en = 1'b1; m_force_val = 14'h3FFF;
        run_req(1'b1, 7'h01, 7'h01, 14'h3FFF, 7'h7F, 1'b0, 10, 1'b1);
        m_force_en = 1'b0;

        // Req withdrawn before any edge samples it: no operation
        @(posedge clk); #1;
        bus.req0 = 1'b1;
        @(negedge clk);
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_grant_busy", bus.busy, 1'b0);

        // Reset during WAIT, then req1 alone
        m_delay = 20;
        bus.a0 = 7'h40; bus.b0 = 7'h40; bus.req0 = 1'b1;
        for (int i = 0; i < 20 && !bus.mult_start; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        m_delay = 8;
        run_req(1'b1, 7'h7F, 7'h7F, 14'h3F01, 7'h7E, 1'b0, 10, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
